axi_mst_initiator: RTL
======================

Name: axi_mst_initiator

Overview:
- AXI3-style master traffic initiator for the crossbar bench; drives one crossbar slave port, which is an upstream master port.
- Accepts simple commands on a valid/ready command port and issues AW+W or AR bursts.
- Tracks outstanding transactions and consumes B/R responses with in-order burst-length checking.
- Counterpart of the slave-side responder model; synthesizable apart from the optional random-ready feature.

Parameters:
AXI_ADDR_W, 32, address width
AXI_ID_W, 4, ID width
AXI_DATA_W, 32, data width (8..1024, power of 2)
MST_OSTD_NUM, 4, max outstanding writes and, separately, max outstanding reads (power of 2, >=2)

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
srst  in  1  sync active-high clear, same effect as reset
cmd_valid/cmd_ready  in/out  1/1  command handshake
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  AXI_ADDR_W  start address
cmd_len  in  4  burst length-1
cmd_id  in  AXI_ID_W  transaction ID
awvalid,awready,awaddr,awlen[4],awsize[3],awburst[2],awid  out/in/out...  AW channel
wvalid,wready,wid,wdata,wstrb[AXI_DATA_W/8],wlast  out/in/out...  W channel
bvalid,bready,bid,bresp[2]  in/out/in/in  B channel
arvalid,arready,araddr,arlen[4],arsize[3],arburst[2],arid  out/in/out...  AR channel
rvalid,rready,rid,rdata,rresp[2],rlast  in/out/in...  R channel
wr_ostd  out  $clog2(MST_OSTD_NUM)+1  outstanding writes
rd_ostd  out  $clog2(MST_OSTD_NUM)+1  outstanding reads
err_flag  out  1  sticky protocol/response error

Behaviour:
- Reset (aresetn low or srst): all valids 0; wr_ostd, rd_ostd and err_flag 0; FSMs to IDLE; FIFO empty. bready/rready are 0 during reset and 1 from the first cycle after reset.
- Write FSM W_IDLE->W_AW->W_DATA->W_IDLE:
  - W_IDLE, cmd handshake with cmd_wr=1: capture cmd, go to W_AW.
  - W_AW: awvalid=1 held stable until awready. On handshake wr_ostd++ and go to W_DATA.
  - W_DATA: wvalid=1; beat counter 0..awlen. wdata = captured addr + beat index (zero-extended). wstrb all ones. wid = awid. wlast on beat==awlen. Return to W_IDLE after the wlast handshake.
  - No W beat before its AW handshake.
- Read FSM R_IDLE->R_AR->R_IDLE:
  - R_AR: arvalid held until arready.
  - On handshake: rd_ostd++ and push {arlen, arid} into the length FIFO.
- cmd_ready:
  - write: W_IDLE and wr_ostd<MST_OSTD_NUM.
  - read: R_IDLE and rd_ostd<MST_OSTD_NUM.
  - cmd_ready is combinational from state only, never from cmd_valid.
- Fixed AW/AR fields: awsize/arsize = $clog2(AXI_DATA_W/8); awburst/arburst = 2'b01 (INCR).
- B handshake: wr_ostd--. If AW handshake and B handshake occur in the same cycle, wr_ostd holds.
- R: rx beat counter; on each R handshake compare against FIFO head.
  - On rlast: pop FIFO, rd_ostd--, clear rx counter. Simultaneous AR push and R pop are both legal; rd_ostd holds.
- err_flag set, never cleared except by reset/srst, on any of:
  - B with wr_ostd==0; R with rd_ostd==0.
  - bresp!=0 or rresp!=0.
  - rlast on a beat != head len, or beat==head len without rlast.
  - rid != head id.
- Counters saturate; no wrap. Full is blocked by cmd_ready, so overflow cannot occur.
- Reset mid-burst abandons the transaction; no recovery.

Optional Feature:
- AXI_MST_RND_READY_EN defined: bready and rready are driven from a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1), bits 0 and 1 respectively, advancing every cycle. Responses may stall.
- Not defined: bready = rready = 1 after reset.

Decomposition:
- Package axi_tb_pkg: AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, typedefs for the write and read FSM state enums, and a cmd_t struct {wr, addr, len, id}.
- One sub-module: axi_ostd_fifo, a sync FIFO with DEPTH=MST_OSTD_NUM, width 4+AXI_ID_W, push/pop/full/empty outputs, and simultaneous push+pop supported when full.

Test Plan:
- Write cmd addr=0x100, len=3, id=2, awready/wready=1, bvalid 2 cycles after wlast -> AW beat 0x100/awlen 3; wdata 0x100..0x103 with wlast on the 4th beat; wr_ostd 1 then 0; err_flag 0.
- Five back-to-back write cmds, bvalid held 0 -> cmd_ready drops after the 4th AW handshake (wr_ostd=4); after one B, 5th AW issues.
- Read cmd len=1, id=5; responder returns 2 beats with rlast on the 2nd -> rd_ostd 1 then 0; err_flag 0.
- Read len=3, responder asserts rlast on beat 2 -> err_flag=1 and stays 1 until srst pulse, then 0.
- Same-cycle AR handshake and final R beat of the previous read, rd_ostd=1 -> rd_ostd stays 1; FIFO head advances to the new len.
- aresetn low in W_DATA beat 1 -> next cycle after release: wvalid=0, wr_ostd=0, cmd_ready=1.

Source files
------------

// File: rtl/axi_tb_pkg.sv
// axi_tb_pkg: shared AXI constants, FSM state types and the command record for the crossbar bench.
package axi_tb_pkg;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam int CMD_ADDR_W = 64;
   localparam int CMD_ID_W = 16;
   typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA} w_state_t;
   typedef enum logic {R_IDLE, R_AR} r_state_t;
   // Widest command any bench instance carries; narrower instances slice it.
   typedef struct packed {
      logic wr;
      logic [CMD_ADDR_W-1:0] addr;
      logic [3:0] len;
      logic [CMD_ID_W-1:0] id;
   } cmd_t;
endpackage

// File: rtl/axi_ostd_fifo.sv
// axi_ostd_fifo: sync FIFO of outstanding read {len, id}; push and pop may coincide even when full.
module axi_ostd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             srst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic do_push, do_pop;
   assign empty = wp == rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = mem[rp[AW-1:0]];
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         wp <= '0;
         rp <= '0;
      end else if (srst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + (AW+1)'(1);
         if (do_pop) rp <= rp + (AW+1)'(1);
      end
   always_ff @(posedge aclk)
      if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/axi_mst_initiator.sv
// axi_mst_initiator: AXI3 master traffic initiator issuing AW+W / AR bursts from a command port.
// Define AXI_MST_RND_READY_EN to drive bready/rready from an LFSR instead of holding them high.
module axi_mst_initiator
   import axi_tb_pkg::*;
#(
   parameter int AXI_ADDR_W   = 32,
   parameter int AXI_ID_W     = 4,
   parameter int AXI_DATA_W   = 32,
   parameter int MST_OSTD_NUM = 4
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          srst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_wr,
   input  logic [AXI_ADDR_W-1:0]         cmd_addr,
   input  logic [3:0]                    cmd_len,
   input  logic [AXI_ID_W-1:0]           cmd_id,
   output logic                          awvalid,
   input  logic                          awready,
   output logic [AXI_ADDR_W-1:0]         awaddr,
   output logic [3:0]                    awlen,
   output logic [2:0]                    awsize,
   output logic [1:0]                    awburst,
   output logic [AXI_ID_W-1:0]           awid,
   output logic                          wvalid,
   input  logic                          wready,
   output logic [AXI_ID_W-1:0]           wid,
   output logic [AXI_DATA_W-1:0]         wdata,
   output logic [AXI_DATA_W/8-1:0]       wstrb,
   output logic                          wlast,
   input  logic                          bvalid,
   output logic                          bready,
   input  logic [AXI_ID_W-1:0]           bid,
   input  logic [1:0]                    bresp,
   output logic                          arvalid,
   input  logic                          arready,
   output logic [AXI_ADDR_W-1:0]         araddr,
   output logic [3:0]                    arlen,
   output logic [2:0]                    arsize,
   output logic [1:0]                    arburst,
   output logic [AXI_ID_W-1:0]           arid,
   input  logic                          rvalid,
   output logic                          rready,
   input  logic [AXI_ID_W-1:0]           rid,
   input  logic [AXI_DATA_W-1:0]         rdata,
   input  logic [1:0]                    rresp,
   input  logic                          rlast,
   output logic [$clog2(MST_OSTD_NUM):0] wr_ostd,
   output logic [$clog2(MST_OSTD_NUM):0] rd_ostd,
   output logic                          err_flag
);
   localparam int OW = $clog2(MST_OSTD_NUM) + 1;
   localparam logic [OW-1:0] OSTD_MAX = OW'(MST_OSTD_NUM);
   w_state_t w_state;
   r_state_t r_state;
   logic [3:0] w_beat, rx_beat, head_len;
   logic [AXI_ID_W-1:0] head_id;
   logic [3+AXI_ID_W:0] head;
   logic cmd_hs, aw_hs, ar_hs, b_hs, r_hs, b_dec, fifo_pop, fifo_full, fifo_empty, b_err, r_err;
   logic unused_ok;
   assign unused_ok = ^{bid, rdata};
   assign cmd_ready = cmd_wr ? (w_state == W_IDLE && wr_ostd < OSTD_MAX) : (r_state == R_IDLE && !fifo_full);
   assign cmd_hs = cmd_valid && cmd_ready;
   assign aw_hs = awvalid && awready;
   assign ar_hs = arvalid && arready;
   assign b_hs = bvalid && bready;
   assign r_hs = rvalid && rready;
   assign awsize = 3'($clog2(AXI_DATA_W / 8));
   assign arsize = 3'($clog2(AXI_DATA_W / 8));
   assign awburst = AXI_BURST_INCR;
   assign arburst = AXI_BURST_INCR;
   assign wid = awid;
   assign wstrb = '1;
   assign wlast = w_beat == awlen;
   assign wdata = AXI_DATA_W'(awaddr) + AXI_DATA_W'(w_beat);
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         w_state <= W_IDLE;
         awvalid <= 1'b0;
         wvalid <= 1'b0;
      end else if (srst) begin
         w_state <= W_IDLE;
         awvalid <= 1'b0;
         wvalid <= 1'b0;
      end else case (w_state)
         W_IDLE: if (cmd_hs && cmd_wr) begin
            awaddr <= cmd_addr;
            awlen <= cmd_len;
            awid <= cmd_id;
            awvalid <= 1'b1;
            w_state <= W_AW;
         end
         W_AW: if (awready) begin
            awvalid <= 1'b0;
            wvalid <= 1'b1;
            w_beat <= '0;
            w_state <= W_DATA;
         end
         default: if (wready) begin
            if (wlast) begin
               wvalid <= 1'b0;
               w_state <= W_IDLE;
            end else w_beat <= w_beat + 4'd1;
         end
      endcase
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         r_state <= R_IDLE;
         arvalid <= 1'b0;
      end else if (srst) begin
         r_state <= R_IDLE;
         arvalid <= 1'b0;
      end else if (r_state == R_IDLE) begin
         if (cmd_hs && !cmd_wr) begin
            araddr <= cmd_addr;
            arlen <= cmd_len;
            arid <= cmd_id;
            arvalid <= 1'b1;
            r_state <= R_AR;
         end
      end else if (arready) begin
         arvalid <= 1'b0;
         r_state <= R_IDLE;
      end
   axi_ostd_fifo #(.DEPTH(MST_OSTD_NUM), .WIDTH(4 + AXI_ID_W)) u_fifo (
      .aclk(aclk), .aresetn(aresetn), .srst(srst),
      .push(ar_hs), .din({arlen, arid}), .pop(fifo_pop), .dout(head),
      .full(fifo_full), .empty(fifo_empty)
   );
   assign head_len = head[3+AXI_ID_W -: 4];
   assign head_id = head[AXI_ID_W-1:0];
   assign fifo_pop = r_hs && rlast && !fifo_empty;
   assign b_dec = b_hs && wr_ostd != '0;
   assign b_err = b_hs && (wr_ostd == '0 || bresp != AXI_RESP_OKAY);
   // A burst must end exactly on its recorded length, with the ID it was issued under.
   assign r_err = r_hs && (fifo_empty || rresp != AXI_RESP_OKAY || rid != head_id || rlast != (rx_beat == head_len));
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         wr_ostd <= '0;
         rd_ostd <= '0;
         rx_beat <= '0;
         err_flag <= 1'b0;
      end else if (srst) begin
         wr_ostd <= '0;
         rd_ostd <= '0;
         rx_beat <= '0;
         err_flag <= 1'b0;
      end else begin
         wr_ostd <= wr_ostd + OW'(aw_hs) - OW'(b_dec);
         rd_ostd <= rd_ostd + OW'(ar_hs) - OW'(fifo_pop);
         if (r_hs && !fifo_empty) rx_beat <= rlast ? 4'd0 : (rx_beat == 4'hF ? rx_beat : rx_beat + 4'd1);
         err_flag <= err_flag || b_err || r_err;
      end
`ifdef AXI_MST_RND_READY_EN
   logic [15:0] lfsr;
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         lfsr <= 16'hACE1;
         bready <= 1'b0;
         rready <= 1'b0;
      end else if (srst) begin
         lfsr <= 16'hACE1;
         bready <= 1'b0;
         rready <= 1'b0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         bready <= lfsr[0];
         rready <= lfsr[1];
      end
`else
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         bready <= 1'b0;
         rready <= 1'b0;
      end else if (srst) begin
         bready <= 1'b0;
         rready <= 1'b0;
      end else begin
         bready <= 1'b1;
         rready <= 1'b1;
      end
`endif
endmodule
